// File: rtl/axi_lite_bram_ctrl.sv
// axi_lite_bram_ctrl
// AXI4-Lite slave in front of a single-clock block RAM of DEPTH words, each
// BUS_WIDTH bytes wide. Independent write (AW/W/B) and read (AR/R) state
// machines, byte-strobed writes, read-first RAM behaviour.
//
// Parameters : ADDRESS_WIDTH (byte address width), BUS_WIDTH (bytes per word),
//              DEPTH (words), BIN_FILE (preload image name).
// Ports      : aclk, arstn (synchronous, active-low),
//              s_axi_aw* / s_axi_w* / s_axi_b*  write address, data, response,
//              s_axi_ar* / s_axi_r*             read address, data/response.
// Build macro: AXI_LITE_BRAM_RANGE_CHECK_EN -- when defined, word indices
//              >= DEPTH are rejected with SLVERR (no RAM write, read data 0).
//              When undefined the index is truncated to the RAM address width.
`timescale 1ns/1ps
module axi_lite_bram_ctrl #(
  parameter int ADDRESS_WIDTH = 16,
  parameter int BUS_WIDTH     = 4,
  parameter int DEPTH         = 512,
  parameter     BIN_FILE      = ""
) (
  input  logic                       aclk,
  input  logic                       arstn,
  input  logic                       s_axi_awvalid,
  output logic                       s_axi_awready,
  input  logic [ADDRESS_WIDTH-1:0]   s_axi_awaddr,
  input  logic [2:0]                 s_axi_awprot,
  input  logic                       s_axi_wvalid,
  output logic                       s_axi_wready,
  input  logic [BUS_WIDTH*8-1:0]     s_axi_wdata,
  input  logic [BUS_WIDTH-1:0]       s_axi_wstrb,
  output logic                       s_axi_bvalid,
  input  logic                       s_axi_bready,
  output logic [1:0]                 s_axi_bresp,
  input  logic                       s_axi_arvalid,
  output logic                       s_axi_arready,
  input  logic [ADDRESS_WIDTH-1:0]   s_axi_araddr,
  input  logic [2:0]                 s_axi_arprot,
  output logic                       s_axi_rvalid,
  input  logic                       s_axi_rready,
  output logic [BUS_WIDTH*8-1:0]     s_axi_rdata,
  output logic [1:0]                 s_axi_rresp
);

  localparam int DATA_WIDTH  = BUS_WIDTH * 8;
  localparam int OFFSET_BITS = (BUS_WIDTH > 1) ? $clog2(BUS_WIDTH) : 0;
  localparam int INDEX_WIDTH = ADDRESS_WIDTH - OFFSET_BITS;
  localparam int RAM_AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [1:0] {W_IDLE = 2'd0, W_EXEC = 2'd1, W_RESP = 2'd2} w_state_t;
  typedef enum logic [1:0] {R_IDLE = 2'd0, R_READ = 2'd1, R_RESP = 2'd2} r_state_t;

`ifdef AXI_LITE_BRAM_RANGE_CHECK_EN
  localparam logic [INDEX_WIDTH:0] DEPTH_LIMIT = (INDEX_WIDTH + 1)'(DEPTH);
`endif

  // True when a word index falls outside the populated RAM.
  function automatic logic range_err(input logic [INDEX_WIDTH-1:0] idx);
`ifdef AXI_LITE_BRAM_RANGE_CHECK_EN
    range_err = ({1'b0, idx} >= DEPTH_LIMIT);
`else
    range_err = &{1'b0, idx};  // always 0: no range check in this build
`endif
  endfunction

  logic [DATA_WIDTH-1:0] mem [0:DEPTH-1];

  w_state_t                 w_state_r, w_state_s;
  logic                     aw_cap_r, aw_cap_s, w_cap_r, w_cap_s;
  logic [INDEX_WIDTH-1:0]   aw_idx_r, aw_idx_s;
  logic [DATA_WIDTH-1:0]    w_data_r, w_data_s;
  logic [BUS_WIDTH-1:0]     w_strb_r, w_strb_s;
  logic                     awready_r, awready_s, wready_r, wready_s;
  logic                     bvalid_r, bvalid_s;
  logic [1:0]               bresp_r, bresp_s;
  logic                     ram_we_s;

  r_state_t                 r_state_r, r_state_s;
  logic [INDEX_WIDTH-1:0]   ar_idx_r, ar_idx_s;
  logic                     rd_stage_r, rd_stage_s;
  logic                     arready_r, arready_s;
  logic                     rvalid_r, rvalid_s;
  logic [1:0]               rresp_r, rresp_s;
  logic [DATA_WIDTH-1:0]    rdata_r, rdata_s;
  logic [DATA_WIDTH-1:0]    ram_q_r;
  logic                     ram_re_s;

  // Write FSM next-state: capture AW and W independently, then one execute cycle.
  always_comb begin
    w_state_s = w_state_r;
    aw_cap_s  = aw_cap_r;
    w_cap_s   = w_cap_r;
    aw_idx_s  = aw_idx_r;
    w_data_s  = w_data_r;
    w_strb_s  = w_strb_r;
    awready_s = awready_r;
    wready_s  = wready_r;
    bvalid_s  = bvalid_r;
    bresp_s   = bresp_r;
    ram_we_s  = 1'b0;
    case (w_state_r)
      W_IDLE: begin
        if (s_axi_awvalid && awready_r) begin
          aw_cap_s = 1'b1;
          aw_idx_s = s_axi_awaddr[ADDRESS_WIDTH-1:OFFSET_BITS];
        end else begin
          aw_cap_s = aw_cap_r;
        end
        if (s_axi_wvalid && wready_r) begin
          w_cap_s  = 1'b1;
          w_data_s = s_axi_wdata;
          w_strb_s = s_axi_wstrb;
        end else begin
          w_cap_s = w_cap_r;
        end
        // Ready is withdrawn on the edge that completes a capture.
        if (aw_cap_s && w_cap_s) begin
          w_state_s = W_EXEC;
          awready_s = 1'b0;
          wready_s  = 1'b0;
        end else begin
          awready_s = !aw_cap_s;
          wready_s  = !w_cap_s;
        end
      end
      W_EXEC: begin
        ram_we_s  = !range_err(aw_idx_r);
        bvalid_s  = 1'b1;
        bresp_s   = range_err(aw_idx_r) ? 2'b10 : 2'b00;
        w_state_s = W_RESP;
      end
      W_RESP: begin
        if (s_axi_bready && bvalid_r) begin
          bvalid_s  = 1'b0;
          bresp_s   = 2'b00;
          aw_cap_s  = 1'b0;
          w_cap_s   = 1'b0;
          awready_s = 1'b1;
          wready_s  = 1'b1;
          w_state_s = W_IDLE;
        end else begin
          w_state_s = W_RESP;
        end
      end
      default: begin
        w_state_s = W_IDLE;
        aw_cap_s  = 1'b0;
        w_cap_s   = 1'b0;
        awready_s = 1'b0;
        wready_s  = 1'b0;
        bvalid_s  = 1'b0;
        bresp_s   = 2'b00;
      end
    endcase
  end

  // Write FSM state and registered write-channel outputs.
  always_ff @(posedge aclk) begin
    if (!arstn) begin
      w_state_r <= W_IDLE;
      aw_cap_r  <= 1'b0;
      w_cap_r   <= 1'b0;
      aw_idx_r  <= {INDEX_WIDTH{1'b0}};
      w_data_r  <= {DATA_WIDTH{1'b0}};
      w_strb_r  <= {BUS_WIDTH{1'b0}};
      awready_r <= 1'b0;
      wready_r  <= 1'b0;
      bvalid_r  <= 1'b0;
      bresp_r   <= 2'b00;
    end else begin
      w_state_r <= w_state_s;
      aw_cap_r  <= aw_cap_s;
      w_cap_r   <= w_cap_s;
      aw_idx_r  <= aw_idx_s;
      w_data_r  <= w_data_s;
      w_strb_r  <= w_strb_s;
      awready_r <= awready_s;
      wready_r  <= wready_s;
      bvalid_r  <= bvalid_s;
      bresp_r   <= bresp_s;
    end
  end

  // Read FSM next-state: R_READ spends one cycle on the RAM read and one on
  // loading the output register, so rvalid appears two edges after AR.
  always_comb begin
    r_state_s  = r_state_r;
    ar_idx_s   = ar_idx_r;
    rd_stage_s = rd_stage_r;
    arready_s  = arready_r;
    rvalid_s   = rvalid_r;
    rresp_s    = rresp_r;
    rdata_s    = rdata_r;
    ram_re_s   = 1'b0;
    case (r_state_r)
      R_IDLE: begin
        if (s_axi_arvalid && arready_r) begin
          ar_idx_s   = s_axi_araddr[ADDRESS_WIDTH-1:OFFSET_BITS];
          arready_s  = 1'b0;
          rd_stage_s = 1'b0;
          r_state_s  = R_READ;
        end else begin
          arready_s = 1'b1;
        end
      end
      R_READ: begin
        if (rd_stage_r) begin
          rvalid_s   = 1'b1;
          rdata_s    = range_err(ar_idx_r) ? {DATA_WIDTH{1'b0}} : ram_q_r;
          rresp_s    = range_err(ar_idx_r) ? 2'b10 : 2'b00;
          rd_stage_s = 1'b0;
          r_state_s  = R_RESP;
        end else begin
          ram_re_s   = 1'b1;
          rd_stage_s = 1'b1;
        end
      end
      R_RESP: begin
        if (s_axi_rready && rvalid_r) begin
          rvalid_s  = 1'b0;
          rresp_s   = 2'b00;
          arready_s = 1'b1;
          r_state_s = R_IDLE;
        end else begin
          r_state_s = R_RESP;
        end
      end
      default: begin
        r_state_s  = R_IDLE;
        rd_stage_s = 1'b0;
        arready_s  = 1'b0;
        rvalid_s   = 1'b0;
        rresp_s    = 2'b00;
      end
    endcase
  end

  // Read FSM state and registered read-channel outputs.
  always_ff @(posedge aclk) begin
    if (!arstn) begin
      r_state_r  <= R_IDLE;
      ar_idx_r   <= {INDEX_WIDTH{1'b0}};
      rd_stage_r <= 1'b0;
      arready_r  <= 1'b0;
      rvalid_r   <= 1'b0;
      rresp_r    <= 2'b00;
      rdata_r    <= {DATA_WIDTH{1'b0}};
    end else begin
      r_state_r  <= r_state_s;
      ar_idx_r   <= ar_idx_s;
      rd_stage_r <= rd_stage_s;
      arready_r  <= arready_s;
      rvalid_r   <= rvalid_s;
      rresp_r    <= rresp_s;
      rdata_r    <= rdata_s;
    end
  end

  // RAM array: byte-strobed write port and read-first registered read port.
  always_ff @(posedge aclk) begin
    for (int b = 0; b < BUS_WIDTH; b++) begin
      if (ram_we_s && w_strb_r[b]) begin
        mem[aw_idx_r[RAM_AW-1:0]][8*b +: 8] <= w_data_r[8*b +: 8];
      end
    end
    if (ram_re_s) begin
      ram_q_r <= mem[ar_idx_r[RAM_AW-1:0]];
    end
  end

  assign s_axi_awready = awready_r;
  assign s_axi_wready  = wready_r;
  assign s_axi_bvalid  = bvalid_r;
  assign s_axi_bresp   = bresp_r;
  assign s_axi_arready = arready_r;
  assign s_axi_rvalid  = rvalid_r;
  assign s_axi_rdata   = rdata_r;
  assign s_axi_rresp   = rresp_r;

  // Protection bits, byte-offset bits and (without range check) the upper
  // index bits carry no meaning for this memory.
  logic unused_s;
  assign unused_s = &{1'b0, s_axi_awprot, s_axi_arprot, s_axi_awaddr,
                      s_axi_araddr, aw_idx_r, ar_idx_r};

endmodule

// File: tb/tb_axi_lite_bram_ctrl.sv
`timescale 1ns/1ps
module tb_axi_lite_bram_ctrl;

  logic        clk = 1'b0;
  logic        arstn = 1'b0;
  logic        awvalid = 1'b0, wvalid = 1'b0, bready = 1'b0;
  logic        arvalid = 1'b0, rready = 1'b0;
  logic [15:0] awaddr = 16'h0000, araddr = 16'h0000;
  logic [31:0] wdata = 32'h0000_0000;
  logic [3:0]  wstrb = 4'h0;
  logic        awready, wready, bvalid, arready, rvalid;
  logic [1:0]  bresp, rresp;
  logic [31:0] rdata;

  int n_checks = 0;
  int n_fail   = 0;

  axi_lite_bram_ctrl #(.ADDRESS_WIDTH(16), .BUS_WIDTH(4), .DEPTH(512)) dut (
    .aclk(clk), .arstn(arstn),
    .s_axi_awvalid(awvalid), .s_axi_awready(awready), .s_axi_awaddr(awaddr),
    .s_axi_awprot(3'b000),
    .s_axi_wvalid(wvalid), .s_axi_wready(wready), .s_axi_wdata(wdata),
    .s_axi_wstrb(wstrb),
    .s_axi_bvalid(bvalid), .s_axi_bready(bready), .s_axi_bresp(bresp),
    .s_axi_arvalid(arvalid), .s_axi_arready(arready), .s_axi_araddr(araddr),
    .s_axi_arprot(3'b000),
    .s_axi_rvalid(rvalid), .s_axi_rready(rready), .s_axi_rdata(rdata),
    .s_axi_rresp(rresp)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Full write transaction; lat = edges from final AW/W handshake to bvalid.
  task automatic do_write(input logic [15:0] addr, input logic [31:0] data,
                          input logic [3:0] strb, output logic [1:0] resp,
                          output int lat, output bit ok);
    bit aw_done = 1'b0, w_done = 1'b0, aw_hs, w_hs;
    ok = 1'b1;
    awaddr = addr; wdata = data; wstrb = strb;
    awvalid = 1'b1; wvalid = 1'b1;
    for (int i = 0; i < 20 && !(aw_done && w_done); i++) begin
      aw_hs = awvalid && awready;
      w_hs  = wvalid && wready;
      tick();
      if (aw_hs) begin aw_done = 1'b1; awvalid = 1'b0; end
      if (w_hs)  begin w_done  = 1'b1; wvalid  = 1'b0; end
    end
    awvalid = 1'b0; wvalid = 1'b0;
    if (!(aw_done && w_done)) ok = 1'b0;
    lat = 0;
    while (!bvalid && lat < 20) begin tick(); lat++; end
    if (!bvalid) ok = 1'b0;
    resp = bresp;
    bready = 1'b1;
    tick();
    bready = 1'b0;
  endtask

  // Full read transaction; lat = edges from AR handshake to rvalid.
  task automatic do_read(input logic [15:0] addr, output logic [31:0] data,
                         output logic [1:0] resp, output int lat, output bit ok);
    bit ar_done = 1'b0, ar_hs;
    ok = 1'b1;
    araddr = addr;
    arvalid = 1'b1;
    for (int i = 0; i < 20 && !ar_done; i++) begin
      ar_hs = arvalid && arready;
      tick();
      if (ar_hs) begin ar_done = 1'b1; arvalid = 1'b0; end
    end
    arvalid = 1'b0;
    if (!ar_done) ok = 1'b0;
    lat = 0;
    while (!rvalid && lat < 20) begin tick(); lat++; end
    if (!rvalid) ok = 1'b0;
    data = rdata; resp = rresp;
    rready = 1'b1;
    tick();
    rready = 1'b0;
  endtask

  task automatic test_reset();
    arstn = 1'b0;
    awvalid = 1'b1; wvalid = 1'b1; arvalid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      n_checks++;
      if ({awready, wready, arready, bvalid, rvalid} !== 5'b00000) begin
        n_fail++;
        $display("FAIL reset_ctrl cycle %0d: got %b expected 00000", i,
                 {awready, wready, arready, bvalid, rvalid});
      end
    end
    n_checks++;
    if ({bresp, rresp, rdata} !== {2'b00, 2'b00, 32'h0000_0000}) begin
      n_fail++;
      $display("FAIL reset_data: bresp %b rresp %b rdata %h expected 00 00 0", bresp, rresp, rdata);
    end
    awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
    arstn = 1'b1;
    tick();
    n_checks++;
    if ({awready, wready, arready} !== 3'b111) begin
      n_fail++;
      $display("FAIL reset_release: readies %b expected 111", {awready, wready, arready});
    end
  endtask

  task automatic test_full_write_read();
    logic [1:0] resp; logic [31:0] d; int lat; bit ok;
    do_write(16'h0010, 32'hDEAD_BEEF, 4'b1111, resp, lat, ok);
    n_checks++;
    if (!ok || resp !== 2'b00 || lat != 1) begin
      n_fail++;
      $display("FAIL full_write: ok %0d bresp %b lat %0d expected 1 00 1", ok, resp, lat);
    end
    do_read(16'h0010, d, resp, lat, ok);
    n_checks++;
    if (!ok || d !== 32'hDEAD_BEEF || resp !== 2'b00 || lat != 2) begin
      n_fail++;
      $display("FAIL full_read: ok %0d rdata %h rresp %b lat %0d expected 1 deadbeef 00 2", ok, d, resp, lat);
    end
  endtask

  task automatic test_byte_strobes();
    logic [1:0] resp; logic [31:0] d; int lat; bit ok;
    do_write(16'h0014, 32'h1122_3344, 4'b1111, resp, lat, ok);
    do_write(16'h0014, 32'hAABB_CCDD, 4'b0101, resp, lat, ok);
    do_read(16'h0014, d, resp, lat, ok);
    n_checks++;
    if (!ok || d !== 32'h11BB_33DD) begin
      n_fail++;
      $display("FAIL strobe_0101: ok %0d rdata %h expected 11bb33dd", ok, d);
    end
    do_write(16'h0014, 32'hFFFF_FFFF, 4'b0000, resp, lat, ok);
    n_checks++;
    if (!ok || resp !== 2'b00) begin
      n_fail++;
      $display("FAIL strobe_0000_resp: ok %0d bresp %b expected 00", ok, resp);
    end
    do_read(16'h0017, d, resp, lat, ok);  // unaligned -> same word
    n_checks++;
    if (!ok || d !== 32'h11BB_33DD) begin
      n_fail++;
      $display("FAIL strobe_0000_data: ok %0d rdata %h expected 11bb33dd", ok, d);
    end
  endtask

  task automatic test_aw_w_split();
    logic [1:0] resp; logic [31:0] d; int lat; bit ok;
    awaddr = 16'h0018; wdata = 32'h5566_7788; wstrb = 4'b1111;
    wvalid = 1'b1;
    tick();
    wvalid = 1'b0;
    n_checks++;
    if ({awready, wready} !== 2'b10) begin
      n_fail++;
      $display("FAIL split_w_only: awready/wready %b expected 10", {awready, wready});
    end
    tick(); tick();
    awvalid = 1'b1;
    tick();
    awvalid = 1'b0;
    n_checks++;
    if ({bvalid, awready} !== 2'b00) begin
      n_fail++;
      $display("FAIL split_exec: bvalid/awready %b expected 00", {bvalid, awready});
    end
    tick();
    for (int i = 0; i < 5; i++) begin
      n_checks++;
      if ({bvalid, bresp, awready, wready} !== 5'b10000) begin
        n_fail++;
        $display("FAIL split_hold cycle %0d: bvalid/bresp/awready/wready %b expected 10000", i,
                 {bvalid, bresp, awready, wready});
      end
      tick();
    end
    bready = 1'b1;
    tick();
    bready = 1'b0;
    n_checks++;
    if ({bvalid, awready, wready} !== 3'b011) begin
      n_fail++;
      $display("FAIL split_release: bvalid/awready/wready %b expected 011", {bvalid, awready, wready});
    end
    do_read(16'h0018, d, resp, lat, ok);
    n_checks++;
    if (!ok || d !== 32'h5566_7788) begin
      n_fail++;
      $display("FAIL split_data: ok %0d rdata %h expected 55667788", ok, d);
    end
  endtask

  task automatic test_range();
    logic [1:0] resp; logic [31:0] d; int lat; bit ok;
    do_write(16'h0000, 32'hCAFE_F00D, 4'b1111, resp, lat, ok);
    do_write(16'h0800, 32'h1234_5678, 4'b1111, resp, lat, ok);
`ifdef AXI_LITE_BRAM_RANGE_CHECK_EN
    n_checks++;
    if (!ok || resp !== 2'b10 || lat != 1) begin
      n_fail++;
      $display("FAIL range_wr: ok %0d bresp %b lat %0d expected 1 10 1", ok, resp, lat);
    end
    do_read(16'h0000, d, resp, lat, ok);
    n_checks++;
    if (!ok || d !== 32'hCAFE_F00D) begin
      n_fail++;
      $display("FAIL range_word0: ok %0d rdata %h expected cafef00d", ok, d);
    end
    do_read(16'h0800, d, resp, lat, ok);
    n_checks++;
    if (!ok || d !== 32'h0000_0000 || resp !== 2'b10 || lat != 2) begin
      n_fail++;
      $display("FAIL range_rd: ok %0d rdata %h rresp %b lat %0d expected 1 0 10 2", ok, d, resp, lat);
    end
`else
    n_checks++;
    if (!ok || resp !== 2'b00) begin
      n_fail++;
      $display("FAIL alias_wr: ok %0d bresp %b expected 00", ok, resp);
    end
    do_read(16'h0000, d, resp, lat, ok);
    n_checks++;
    if (!ok || d !== 32'h1234_5678 || resp !== 2'b00) begin
      n_fail++;
      $display("FAIL alias_word0: ok %0d rdata %h rresp %b expected 12345678 00", ok, d, resp);
    end
`endif
  endtask

  task automatic test_concurrency();
    logic [1:0] resp, br; logic [31:0] d, rd; int lat; bit ok, got_b, got_r;
    do_write(16'h0020, 32'h0000_0001, 4'b1111, resp, lat, ok);
    awaddr = 16'h0020; wdata = 32'h0000_0002; wstrb = 4'b1111; araddr = 16'h0020;
    n_checks++;
    if ({awready, wready, arready} !== 3'b111) begin
      n_fail++;
      $display("FAIL conc_ready: readies %b expected 111", {awready, wready, arready});
    end
    awvalid = 1'b1; wvalid = 1'b1; arvalid = 1'b1;
    tick();
    awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
    bready = 1'b1; rready = 1'b1;
    got_b = 1'b0; got_r = 1'b0; br = 2'b11; rd = 32'hFFFF_FFFF;
    for (int i = 0; i < 10; i++) begin
      if (bvalid && !got_b) begin got_b = 1'b1; br = bresp; end
      if (rvalid && !got_r) begin got_r = 1'b1; rd = rdata; end
      tick();
    end
    bready = 1'b0; rready = 1'b0;
    n_checks++;
    if (!got_b || !got_r || br !== 2'b00 || rd !== 32'h0000_0001) begin
      n_fail++;
      $display("FAIL conc_read_first: got_b %0d got_r %0d bresp %b rdata %h expected 1 1 00 00000001",
               got_b, got_r, br, rd);
    end
    do_read(16'h0020, d, resp, lat, ok);
    n_checks++;
    if (!ok || d !== 32'h0000_0002) begin
      n_fail++;
      $display("FAIL conc_new: ok %0d rdata %h expected 00000002", ok, d);
    end
  endtask

  task automatic test_reset_mid_read();
    araddr = 16'h0010;
    arvalid = 1'b1;
    tick();
    arvalid = 1'b0;
    arstn = 1'b0;
    tick();
    n_checks++;
    if ({rvalid, arready} !== 2'b00) begin
      n_fail++;
      $display("FAIL rst_read_hold: rvalid/arready %b expected 00", {rvalid, arready});
    end
    arstn = 1'b1;
    tick();
    n_checks++;
    if ({rvalid, arready} !== 2'b01) begin
      n_fail++;
      $display("FAIL rst_read_release: rvalid/arready %b expected 01", {rvalid, arready});
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      n_checks++;
      if (rvalid !== 1'b0) begin
        n_fail++;
        $display("FAIL rst_read_no_rvalid cycle %0d: rvalid %b expected 0", i, rvalid);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [1:0] resp; logic [31:0] d; int lat; bit ok;
    do_write(16'h0030, 32'hA5A5_0001, 4'b1111, resp, lat, ok);
    do_write(16'h0034, 32'h5A5A_0002, 4'b1111, resp, lat, ok);
    do_read(16'h0030, d, resp, lat, ok);
    n_checks++;
    if (!ok || d !== 32'hA5A5_0001) begin
      n_fail++;
      $display("FAIL b2b_first: ok %0d rdata %h expected a5a50001", ok, d);
    end
    do_read(16'h0034, d, resp, lat, ok);
    n_checks++;
    if (!ok || d !== 32'h5A5A_0002) begin
      n_fail++;
      $display("FAIL b2b_second: ok %0d rdata %h expected 5a5a0002", ok, d);
    end
  endtask

  initial begin
    test_reset();
    test_full_write_read();
    test_byte_strobes();
    test_aw_w_split();
    test_range();
    test_concurrency();
    test_reset_mid_read();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
